// File: rtl/pos_sweep_ctrl.sv
// pos_sweep_ctrl: exhaustive 16-vector truth-table sweeper and checker for a 4-input logic block
// Ports: i_clk/i_rst (sync active-high) clock and reset; i_start/i_abort sweep control;
//        i_expected expected truth table; i_f_in function output; o_a..o_d registered drive;
//        o_busy sweep active; o_done completion pulse; o_pass result; o_captured sampled table;
//        o_fail_idx lowest mismatching vector; o_fail_cnt mismatch count
module pos_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [15:0] i_expected,
   input  logic        i_f_in,
   output logic        o_a,
   output logic        o_b,
   output logic        o_c,
   output logic        o_d,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass,
   output logic [15:0] o_captured,
   output logic [3:0]  o_fail_idx,
   output logic [4:0]  o_fail_cnt
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;
   logic [1:0]  r_state;
   logic [3:0]  r_idx;
   logic [7:0]  r_cnt;
   logic [15:0] r_exp;
   logic [15:0] r_cap;
   logic [3:0]  r_fidx;
   logic [4:0]  r_fcnt;
   logic        r_pass;
   logic        w_last;
   logic        w_miss;
   assign w_last = r_cnt == 8'(SETTLE_CYCLES - 1);
   assign w_miss = i_f_in != r_exp[r_idx];
   // r_idx doubles as the drive register: it is forced to 0 whenever the sweep is not running
   assign {o_a, o_b, o_c, o_d} = r_idx;
   assign o_busy     = r_state != IDLE;
   assign o_done     = r_state == FINISH;
   assign o_pass     = r_pass;
   assign o_captured = r_cap;
   assign o_fail_idx = r_fidx;
   assign o_fail_cnt = r_fcnt;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_exp   <= '0;
         r_cap   <= '0;
         r_fidx  <= '0;
         r_fcnt  <= '0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (i_start && !i_abort) begin
               r_exp   <= i_expected;
               r_cap   <= '0;
               r_fidx  <= '0;
               r_fcnt  <= '0;
               r_pass  <= 1'b0;
               r_idx   <= '0;
               r_cnt   <= '0;
               r_state <= RUN;
            end
            RUN: if (i_abort) begin
               r_state <= IDLE;
               r_idx   <= '0;
               r_pass  <= 1'b0;
            end else if (w_last) begin
               r_cap[r_idx] <= i_f_in;
               r_cnt        <= '0;
               if (w_miss) begin
                  r_fcnt <= r_fcnt + 5'd1;
                  if (r_fcnt == 5'd0) r_fidx <= r_idx;
               end
               if (r_idx == 4'hF) begin
                  r_state <= FINISH;
                  r_idx   <= '0;
                  // fail_cnt is still being updated this edge, so fold in the current vector
                  r_pass  <= (r_fcnt == 5'd0) && !w_miss;
               end else begin
                  r_idx <= r_idx + 4'd1;
               end
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pos_sweep_ctrl.sv
// tb_pos_sweep_ctrl: scoreboard bench for pos_sweep_ctrl with settle windows of 2 and 1
module tb_pos_sweep_ctrl;
   typedef struct packed {
      logic [15:0] cap;
      logic [4:0]  cnt;
      logic [3:0]  idx;
      logic        pass;
   } res_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int passed = 0;
   int total  = 0;
   bit d1_done = 1'b0;
   res_t q2[$];
   res_t q1[$];
   logic        rst2 = 1'b1, start2 = 1'b0, abort2 = 1'b0;
   logic [15:0] exp2 = '0, tt2 = '0;
   logic        a2, b2, c2, d2, busy2, done2, pass2, f2;
   logic [15:0] cap2;
   logic [3:0]  fidx2;
   logic [4:0]  fcnt2;
   logic        rst1 = 1'b1, start1 = 1'b0, abort1 = 1'b0;
   logic [15:0] exp1 = '0, tt1 = '0;
   logic        a1, b1, c1, d1, busy1, done1, pass1, f1;
   logic [15:0] cap1;
   logic [3:0]  fidx1;
   logic [4:0]  fcnt1;
   assign f2 = tt2[{a2, b2, c2, d2}];
   assign f1 = tt1[{a1, b1, c1, d1}];
   pos_sweep_ctrl #(.SETTLE_CYCLES(2)) dut2 (
      .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_abort(abort2), .i_expected(exp2), .i_f_in(f2),
      .o_a(a2), .o_b(b2), .o_c(c2), .o_d(d2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
      .o_captured(cap2), .o_fail_idx(fidx2), .o_fail_cnt(fcnt2));
   pos_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
      .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_abort(abort1), .i_expected(exp1), .i_f_in(f1),
      .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
      .o_captured(cap1), .o_fail_idx(fidx1), .o_fail_cnt(fcnt1));
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) $display("FAIL %s: got %0h, required %0h at %0t", n, act, req, $time);
      else passed++;
   endtask
   // result of checking table t against e over the vectors selected by mask m
   function automatic res_t model(input logic [15:0] t, input logic [15:0] e, input logic [15:0] m);
      res_t r;
      logic [15:0] diff;
      diff   = (t ^ e) & m;
      r.cap  = t & m;
      r.cnt  = 5'($countones(diff));
      r.idx  = '0;
      for (int k = 15; k >= 0; k--) if (diff[k]) r.idx = 4'(k);
      r.pass = (m == 16'hFFFF) && (diff == 16'h0);
      return r;
   endfunction
   task automatic cmp(input string tag, input res_t got, input res_t req);
      chk({tag, "_captured"}, got.cap, req.cap);
      chk({tag, "_fail_cnt"}, got.cnt, req.cnt);
      chk({tag, "_fail_idx"}, got.idx, req.idx);
      chk({tag, "_pass"}, got.pass, req.pass);
   endtask
   always @(negedge clk) if (done2) begin
      if (q2.size() == 0) chk("s2_unexpected_done", 1, 0);
      else cmp("s2", {cap2, fcnt2, fidx2, pass2}, q2.pop_front());
   end
   always @(negedge clk) if (done1) begin
      if (q1.size() == 0) chk("s1_unexpected_done", 1, 0);
      else cmp("s1", {cap1, fcnt1, fidx1, pass1}, q1.pop_front());
   end
   task automatic zeros2(input string n);
      chk({n, "_busy"}, busy2, 0);
      chk({n, "_done"}, done2, 0);
      chk({n, "_drive"}, {a2, b2, c2, d2}, 0);
      chk({n, "_captured"}, cap2, 0);
      chk({n, "_fail_cnt"}, fcnt2, 0);
      chk({n, "_fail_idx"}, fidx2, 0);
      chk({n, "_pass"}, pass2, 0);
   endtask
   task automatic sweep2(input logic [15:0] t, input logic [15:0] e);
      tt2 = t;
      exp2 = e;
      start2 = 1'b1;
      q2.push_back(model(t, e, 16'hFFFF));
      @(posedge clk); #1 start2 = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         chk("s2_drive", {a2, b2, c2, d2}, c <= 32 ? (c - 1) / 2 : 0);
         chk("s2_busy", busy2, c <= 33);
         chk("s2_done", done2, c == 33);
      end
   endtask
   initial begin
      logic [15:0] gtt, t, e;
      res_t r;
      start2 = 1'b1;
      exp2 = 16'hFFFF;
      repeat (2) @(posedge clk);
      #1 zeros2("reset");
      rst2 = 1'b0;
      start2 = 1'b0;
      for (int k = 0; k < 16; k++) gtt[k] = (k[3] | k[2]) & (k[1] | k[0]);
      sweep2(gtt, 16'hEEE0);
      sweep2(gtt, 16'h6EE1);
      start2 = 1'b1;
      abort2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0; abort2 = 1'b0;
      chk("idle_abort_prio_busy", busy2, 0);
      t = 16'($urandom);
      e = 16'($urandom);
      tt2 = t;
      exp2 = e;
      start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int c = 2; c <= 13; c++) begin
         @(posedge clk); #1;
         start2 = (c == 10);
         abort2 = (c == 12);
         if (c == 11) chk("ignored_start_drive", {a2, b2, c2, d2}, 5);
      end
      chk("abort_busy", busy2, 0);
      chk("abort_drive", {a2, b2, c2, d2}, 0);
      cmp("abort", {cap2, fcnt2, fidx2, pass2}, model(t, e, 16'h001F));
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1 chk("abort_no_done", done2, 0);
      end
      tt2 = 16'($urandom);
      exp2 = 16'($urandom);
      start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int c = 2; c <= 21; c++) begin
         @(posedge clk); #1;
         rst2 = (c == 20);
      end
      zeros2("mid_reset");
      sweep2(gtt, 16'hEEE0);
      repeat (8) begin
         t = 16'($urandom);
         e = $urandom_range(0, 1) ? t : t ^ 16'($urandom);
         sweep2(t, e);
      end
      wait (d1_done);
      repeat (3) @(posedge clk);
      chk("q2_drained", q2.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      int n;
      start1 = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("s1_reset_busy", busy1, 0);
      chk("s1_reset_captured", cap1, 0);
      rst1 = 1'b0;
      start1 = 1'b0;
      for (int i = 0; i < 11; i++) begin
         tt1 = i == 0 ? 16'hFFFF : 16'($urandom);
         exp1 = i == 0 ? 16'h0000 : ($urandom_range(0, 1) ? tt1 : tt1 ^ 16'($urandom));
         q1.push_back(model(tt1, exp1, 16'hFFFF));
         start1 = 1'b1;
         @(posedge clk); #1 start1 = 1'b0;
         n = 1;
         while (!done1 && n < 40) begin
            if (n <= 16) chk("s1_drive", {a1, b1, c1, d1}, n - 1);
            @(posedge clk); #1 n++;
         end
         chk("s1_done_latency", n, 17);
         @(posedge clk); #1;
      end
      d1_done = 1'b1;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      total++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/pos_sweep_ctrl.md
# pos_sweep_ctrl

Exhaustive truth-table sweeper for the 4-input reduced POS logic block. On `start` it drives the A, B, C and D inputs through all 16 combinations, waits a programmable settle window per vector, and captures the function output into a 16-bit truth-table word. It compares that word against an expected mask, reports pass/fail, the first failing vector and the mismatch count. It sits between the board switches/LEDs and the combinational function, so the lab function can be checked in hardware without manual switch toggling.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..255.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level-sampled; accepted only in IDLE.
- `abort` input 1: cancels a sweep in progress.
- `expected` input 16: expected truth table, bit k = F(vector k); latched when `start` is accepted.
- `f_in` input 1: output of the function under test.
- `A`, `B`, `C`, `D` output 1 each: registered drive to the function under test; A = idx[3], B = idx[2], C = idx[1], D = idx[0].
- `busy` output 1: high while sweeping.
- `done` output 1: one-cycle pulse when a sweep completes; never pulses on abort.
- `pass` output 1: set at completion when `captured == expected`.
- `captured` output 16: sampled truth table.
- `fail_idx` output 4: lowest mismatching vector index; 0 if none.
- `fail_cnt` output 5: number of mismatching vectors, 0..16.

## Operation
- States: IDLE, RUN, FINISH.
- **IDLE**
  - `busy` = 0; `A..D` = 0.
  - `start` = 1 with `abort` = 0: latch `expected`; clear `captured`, `fail_cnt`, `fail_idx`, `pass`; set idx = 0 and settle counter = 0; go to RUN.
- **RUN**
  - Drive `{A,B,C,D}` = idx and increment the settle counter.
  - On the last settle cycle (counter = `SETTLE_CYCLES`-1):
    - Write `captured[idx]` = `f_in`.
    - If `f_in` ≠ `expected[idx]`: increment `fail_cnt`; load `fail_idx` = idx if this is the first mismatch.
    - If idx = 15, go to FINISH; otherwise idx+1 and reset the counter.
- **FINISH**
  - Assert `done` for this one cycle; `pass` = (`fail_cnt` = 0); `A..D` return to 0.
  - Go to IDLE.
- **Result hold:** `captured`, `fail_*` and `pass` hold until the next accepted `start` or reset.
- **`start` outside IDLE:** ignored, including in the FINISH cycle.
- **`abort` in RUN:** next state IDLE; `A..D` = 0; `pass` = 0; partial `captured`/`fail_*` are kept; no `done`. `abort` has priority over sampling in the same cycle. In IDLE, `abort` has priority over `start`.
- **`rst`:** overrides everything, at any time.
- **Counters:** idx is 4 bits and never wraps, because the sweep terminates at 15. `fail_cnt` saturates naturally at 16.

## Timing
- **Reset values:** state IDLE; all outputs 0, including `captured` = 16'h0000.
- Let the edge that accepts `start` be edge 0.
- `A..D` = vector k during cycles k·S+1 .. (k+1)·S, where S = `SETTLE_CYCLES`.
- `f_in` for vector k is sampled on edge (k+1)·S; `A..D` are stable for S full cycles before each sample.
- `busy` is high from cycle 1 through the FINISH cycle.
- `done` is high in cycle 16·S+1; `pass` is valid from that cycle.
- Total latency from `start` to `done` is 16·S+1 cycles; the next `start` can be accepted at edge 16·S+2.
- `rst` mid-sweep: outputs read reset values on the cycle after the reset edge.

## Test plan
- **Reset:** hold `rst` 2 cycles with `start` = 1 → `busy` = 0, `done` = 0, `A..D` = 0, `captured` = 16'h0000, `fail_cnt` = 0, `pass` = 0.
- **Good sweep:** bench model f = (A|B)&(C|D), S = 2, `expected` = 16'hEEE0 →
  - `A..D` step 0..15, two cycles per vector.
  - `done` pulses in cycle 33; `captured` = 16'hEEE0, `pass` = 1, `fail_cnt` = 0, `fail_idx` = 0.
- **Mismatch:** same model, `expected` = 16'h6EE1 → `captured` = 16'hEEE0, `fail_cnt` = 2, `fail_idx` = 0, `pass` = 0.
- **Abort / ignored start:**
  - `start` pulsed again in cycle 10 → no restart; idx continues.
  - `abort` in cycle 12 → next cycle IDLE, `A..D` = 0, `busy` = 0; `done` stays low for 40 cycles.
- **Reset mid-sweep:** `rst` in cycle 20 → all outputs at reset values next cycle. A fresh `start` then gives a complete, correct 33-cycle sweep.
- **SETTLE_CYCLES = 1:** each vector is held 1 cycle; `done` in cycle 17. With `f_in` stuck at 1 and `expected` = 16'h0000 → `captured` = 16'hFFFF, `fail_cnt` = 16, `fail_idx` = 0.
